// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: turns start/stall/halt/branch requests into registered
// fetch-unit controls, squashes wrong-path fetches and counts issued instructions.
module fetch_controller #(
   parameter int DATA_WIDTH   = 8,
   parameter int FLUSH_CYCLES = 1,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   _CLK,
   input  logic                   _reset,
   input  logic                   _start,
   input  logic                   _stallReq,
   input  logic                   _haltReq,
   input  logic                   _branchReq,
   input  logic                   _branchRelative,
   input  logic [DATA_WIDTH-1:0]  _branchTarget,
   output logic                   fetchRun,
   output logic                   fetchReset,
   output logic                   fetchHalt,
   output logic                   fetchBranchJump,
   output logic                   fetchRelative,
   output logic [DATA_WIDTH-1:0]  fetchDest,
   output logic                   squash,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] insnCount
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_RUN    = 3'd2;
   localparam logic [2:0] S_FLUSH  = 3'd3;
   localparam logic [2:0] S_HALTED = 3'd4;

   localparam logic [2:0]             FLUSH_LOAD = 3'(FLUSH_CYCLES);
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

   logic [2:0]             state, state_nxt;
   logic [2:0]             flush_cnt, flush_cnt_nxt, flush_rem;
   logic                   run_nxt, reset_nxt, halt_nxt, bj_nxt, rel_nxt;
   logic                   squash_nxt, done_nxt, clear_count;
   logic [DATA_WIDTH-1:0]  dest_nxt;
   logic [COUNT_WIDTH-1:0] count_nxt;

   // flush_cnt counts unstalled squash cycles still owed, including the current one
   assign flush_rem = fetchRun ? (flush_cnt - 3'd1) : flush_cnt;

   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      run_nxt       = 1'b0;
      reset_nxt     = 1'b0;
      halt_nxt      = 1'b0;
      bj_nxt        = 1'b0;
      rel_nxt       = 1'b0;
      dest_nxt      = fetchDest;
      squash_nxt    = 1'b0;
      done_nxt      = 1'b0;
      clear_count   = 1'b0;
      case (state)
         S_IDLE: begin
            if (_start) begin
               state_nxt   = S_INIT;
               reset_nxt   = 1'b1;
               clear_count = 1'b1;
            end
         end
         S_INIT: begin
            state_nxt = S_RUN;
            run_nxt   = 1'b1;
         end
         S_RUN: begin
            if (_haltReq) begin
               state_nxt = S_HALTED;
               halt_nxt  = 1'b1;
               done_nxt  = 1'b1;
            end else if (_branchReq) begin
               state_nxt     = S_FLUSH;
               flush_cnt_nxt = FLUSH_LOAD;
               bj_nxt        = 1'b1;
               rel_nxt       = _branchRelative;
               dest_nxt      = _branchTarget;
               run_nxt       = 1'b1;
               squash_nxt    = 1'b1;
            end else begin
               run_nxt  = !_stallReq;
               halt_nxt = _stallReq;
            end
         end
         S_FLUSH: begin
            // halt/branch requests here belong to squashed instructions
            run_nxt  = !_stallReq;
            halt_nxt = _stallReq;
            if (flush_rem == 3'd0) begin
               state_nxt = S_RUN;
            end else begin
               flush_cnt_nxt = flush_rem;
               squash_nxt    = 1'b1;
            end
         end
         S_HALTED: begin
            if (_start) begin
               state_nxt   = S_INIT;
               reset_nxt   = 1'b1;
               clear_count = 1'b1;
            end else begin
               halt_nxt = 1'b1;
               done_nxt = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      count_nxt = insnCount;
      if (clear_count)
         count_nxt = '0;
      else if (fetchRun && !squash && insnCount != COUNT_MAX)
         count_nxt = insnCount + COUNT_WIDTH'(1);
   end

   always_ff @(posedge _CLK or negedge _reset) begin
      if (!_reset) begin
         state           <= S_IDLE;
         flush_cnt       <= 3'd0;
         fetchRun        <= 1'b0;
         fetchReset      <= 1'b0;
         fetchHalt       <= 1'b0;
         fetchBranchJump <= 1'b0;
         fetchRelative   <= 1'b0;
         fetchDest       <= '0;
         squash          <= 1'b0;
         done            <= 1'b0;
         insnCount       <= '0;
      end else begin
         state           <= state_nxt;
         flush_cnt       <= flush_cnt_nxt;
         fetchRun        <= run_nxt;
         fetchReset      <= reset_nxt;
         fetchHalt       <= halt_nxt;
         fetchBranchJump <= bj_nxt;
         fetchRelative   <= rel_nxt;
         fetchDest       <= dest_nxt;
         squash          <= squash_nxt;
         done            <= done_nxt;
         insnCount       <= count_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a default instance (FLUSH_CYCLES=1) and a
// second one (FLUSH_CYCLES=3, COUNT_WIDTH=4) share the same stimulus.
module tb_fetch_controller;

   logic       clk = 1'b0;
   logic       rst_n, start, stall, halt, branch, rel;
   logic [7:0] target;

   logic        a_run, a_rst, a_halt, a_bj, a_rel, a_sq, a_done;
   logic [7:0]  a_dest;
   logic [15:0] a_cnt;
   logic        b_run, b_rst, b_halt, b_bj, b_rel, b_sq, b_done;
   logic [7:0]  b_dest;
   logic [3:0]  b_cnt;
   logic [6:0]  a_ctl, b_ctl;

   int n_cmp = 0;
   int n_err = 0;

   // control bundle order: {run, reset, halt, branchJump, relative, squash, done}
   assign a_ctl = {a_run, a_rst, a_halt, a_bj, a_rel, a_sq, a_done};
   assign b_ctl = {b_run, b_rst, b_halt, b_bj, b_rel, b_sq, b_done};

   always #5 clk = ~clk;

   fetch_controller dut_a (
      ._CLK(clk), ._reset(rst_n), ._start(start), ._stallReq(stall), ._haltReq(halt),
      ._branchReq(branch), ._branchRelative(rel), ._branchTarget(target),
      .fetchRun(a_run), .fetchReset(a_rst), .fetchHalt(a_halt), .fetchBranchJump(a_bj),
      .fetchRelative(a_rel), .fetchDest(a_dest), .squash(a_sq), .done(a_done),
      .insnCount(a_cnt)
   );

   fetch_controller #(.DATA_WIDTH(8), .FLUSH_CYCLES(3), .COUNT_WIDTH(4)) dut_b (
      ._CLK(clk), ._reset(rst_n), ._start(start), ._stallReq(stall), ._haltReq(halt),
      ._branchReq(branch), ._branchRelative(rel), ._branchTarget(target),
      .fetchRun(b_run), .fetchReset(b_rst), .fetchHalt(b_halt), .fetchBranchJump(b_bj),
      .fetchRelative(b_rel), .fetchDest(b_dest), .squash(b_sq), .done(b_done),
      .insnCount(b_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      start = 0; stall = 0; halt = 0; branch = 0; rel = 0; target = 8'h00;
   endtask

   // reset, release, start; leaves both DUTs in RUN with fetchRun=1 and count 0
   task automatic restart();
      clear_inputs();
      rst_n = 0;
      #3;
      tick();
      rst_n = 1;
      tick();
      start = 1;
      tick();
      start = 0;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      #2;
      n_cmp++;
      if ({a_ctl, a_dest, a_cnt, b_ctl, b_dest, b_cnt} !== 50'd0) begin
         n_err++;
         $display("FAIL reset_outputs got a=%b/%h/%0d b=%b/%h/%0d want all 0", a_ctl, a_dest, a_cnt, b_ctl, b_dest, b_cnt);
      end
      start = 1;
      tick();
      n_cmp++;
      if ({a_ctl, a_dest, a_cnt, b_ctl, b_dest, b_cnt} !== 50'd0) begin
         n_err++;
         $display("FAIL reset_held got a=%b b=%b want 0", a_ctl, b_ctl);
      end
      start = 0;
      rst_n = 1;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b0000000) begin
         n_err++;
         $display("FAIL idle_outputs got %b want 0000000", a_ctl);
      end
      start = 1;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b0100000 || a_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL init_cycle got ctl=%b cnt=%0d want 0100000/0", a_ctl, a_cnt);
      end
      start = 0;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b1000000 || b_ctl !== 7'b1000000) begin
         n_err++;
         $display("FAIL first_run got a=%b b=%b want 1000000", a_ctl, b_ctl);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_cmp++;
         if (a_cnt !== 16'(k) || b_cnt !== 4'(k)) begin
            n_err++;
            $display("FAIL count_step%0d got a=%0d b=%0d want %0d", k, a_cnt, b_cnt, k);
         end
      end
   endtask

   task automatic test_relative_branch();
      restart();
      tick();
      branch = 1; rel = 1; target = 8'hFC;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b1001110 || a_dest !== 8'hFC || a_cnt !== 16'd2 || b_ctl !== 7'b1001110) begin
         n_err++;
         $display("FAIL rel_branch got a=%b dest=%h cnt=%0d b=%b want 1001110/fc/2 1001110", a_ctl, a_dest, a_cnt, b_ctl);
      end
      branch = 0; rel = 0; target = 8'h00;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b1000000 || a_dest !== 8'hFC || a_cnt !== 16'd2) begin
         n_err++;
         $display("FAIL rel_after got ctl=%b dest=%h cnt=%0d want 1000000/fc/2", a_ctl, a_dest, a_cnt);
      end
      tick();
      n_cmp++;
      if (a_cnt !== 16'd3) begin
         n_err++;
         $display("FAIL rel_count_resume got %0d want 3", a_cnt);
      end
   endtask

   task automatic test_flush_stall();
      restart();
      branch = 1; rel = 0; target = 8'h40;
      tick();
      n_cmp++;
      if (b_ctl !== 7'b1001010 || b_dest !== 8'h40 || b_cnt !== 4'd1) begin
         n_err++;
         $display("FAIL flush_e1 got %b dest=%h cnt=%0d want 1001010/40/1", b_ctl, b_dest, b_cnt);
      end
      branch = 0; stall = 1;
      tick();
      n_cmp++;
      if (b_ctl !== 7'b0010010 || a_ctl !== 7'b0010000) begin
         n_err++;
         $display("FAIL flush_stall got b=%b a=%b want 0010010 0010000", b_ctl, a_ctl);
      end
      stall = 0; branch = 1; target = 8'h77;
      tick();
      n_cmp++;
      if (b_ctl !== 7'b1000010 || b_dest !== 8'h40) begin
         n_err++;
         $display("FAIL flush_ignore_branch got %b dest=%h want 1000010/40", b_ctl, b_dest);
      end
      n_cmp++;
      if (a_ctl !== 7'b1001010 || a_dest !== 8'h77) begin
         n_err++;
         $display("FAIL abs_branch got %b dest=%h want 1001010/77", a_ctl, a_dest);
      end
      branch = 0;
      tick();
      n_cmp++;
      if (b_ctl !== 7'b1000010) begin
         n_err++;
         $display("FAIL flush_e4 got %b want 1000010", b_ctl);
      end
      tick();
      n_cmp++;
      if (b_ctl !== 7'b1000000 || b_cnt !== 4'd1) begin
         n_err++;
         $display("FAIL flush_exit got %b cnt=%0d want 1000000/1", b_ctl, b_cnt);
      end
      tick();
      n_cmp++;
      if (b_cnt !== 4'd2) begin
         n_err++;
         $display("FAIL flush_count_resume got %0d want 2", b_cnt);
      end
   endtask

   task automatic test_halt_restart();
      restart();
      halt = 1; branch = 1; target = 8'h99;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b0010001 || b_ctl !== 7'b0010001 || a_cnt !== 16'd1) begin
         n_err++;
         $display("FAIL halt_wins got a=%b b=%b cnt=%0d want 0010001/1", a_ctl, b_ctl, a_cnt);
      end
      halt = 0; branch = 0;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b0010001 || a_cnt !== 16'd1 || a_dest !== 8'h00) begin
         n_err++;
         $display("FAIL halted_hold got %b cnt=%0d dest=%h want 0010001/1/00", a_ctl, a_cnt, a_dest);
      end
      start = 1;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b0100000 || a_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL restart_init got %b cnt=%0d want 0100000/0", a_ctl, a_cnt);
      end
      start = 0;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b1000000) begin
         n_err++;
         $display("FAIL restart_run got %b want 1000000", a_ctl);
      end
   endtask

   task automatic test_back_to_back();
      restart();
      stall = 1;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b0010000) begin
         n_err++;
         $display("FAIL run_stall got %b want 0010000", a_ctl);
      end
      stall = 0;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b1000000 || a_cnt !== 16'd1) begin
         n_err++;
         $display("FAIL run_unstall got %b cnt=%0d want 1000000/1", a_ctl, a_cnt);
      end
      stall = 1; branch = 1; rel = 1; target = 8'h11;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b1001110 || a_dest !== 8'h11 || a_cnt !== 16'd2) begin
         n_err++;
         $display("FAIL branch_over_stall got %b dest=%h cnt=%0d want 1001110/11/2", a_ctl, a_dest, a_cnt);
      end
      clear_inputs();
      tick();
   endtask

   task automatic test_saturation();
      restart();
      repeat (15) tick();
      n_cmp++;
      if (b_cnt !== 4'd15 || a_cnt !== 16'd15) begin
         n_err++;
         $display("FAIL sat_reach got b=%0d a=%0d want 15 15", b_cnt, a_cnt);
      end
      repeat (5) tick();
      n_cmp++;
      if (b_cnt !== 4'd15 || a_cnt !== 16'd20) begin
         n_err++;
         $display("FAIL sat_hold got b=%0d a=%0d want 15 20", b_cnt, a_cnt);
      end
   endtask

   task automatic test_reset_mid();
      restart();
      branch = 1; rel = 0; target = 8'h5A;
      tick();
      n_cmp++;
      if (a_ctl !== 7'b1001010 || a_dest !== 8'h5A) begin
         n_err++;
         $display("FAIL pre_reset_branch got %b dest=%h want 1001010/5a", a_ctl, a_dest);
      end
      #2;
      rst_n = 0;
      #1;
      n_cmp++;
      if ({a_ctl, a_dest, a_cnt, b_ctl, b_dest, b_cnt} !== 50'd0) begin
         n_err++;
         $display("FAIL async_reset got a=%b/%h/%0d b=%b/%h/%0d want all 0", a_ctl, a_dest, a_cnt, b_ctl, b_dest, b_cnt);
      end
      clear_inputs();
      tick();
      rst_n = 1;
      tick();
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      test_reset();
      test_relative_branch();
      test_flush_stall();
      test_halt_restart();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
